// File: rtl/gpu_tri_sequencer_if.sv
// gpu_tri_sequencer_if: primitive-in / triangle-out handshake bundle for the
// triangle sequencer. master = upstream splitter + rasterizer side,
// slave = the sequencer itself.
interface gpu_tri_sequencer_if #(
  parameter int CW = 16
);
  // primitive input side
  logic          in_valid;
  logic          in_ready;
  logic          in_is_quad;
  logic [CW-1:0] in_x0_0, in_y0_0, in_x1_0, in_y1_0, in_x2_0, in_y2_0;
  logic [CW-1:0] in_x0_1, in_y0_1, in_x1_1, in_y1_1, in_x2_1, in_y2_1;

  // triangle output side
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          out_idx;
  logic [CW-1:0] out_x0, out_y0, out_x1, out_y1, out_x2, out_y2;

  modport master (
    output in_valid, in_is_quad,
    output in_x0_0, in_y0_0, in_x1_0, in_y1_0, in_x2_0, in_y2_0,
    output in_x0_1, in_y0_1, in_x1_1, in_y1_1, in_x2_1, in_y2_1,
    output out_ready,
    input  in_ready,
    input  out_valid, out_last, out_idx,
    input  out_x0, out_y0, out_x1, out_y1, out_x2, out_y2
  );

  modport slave (
    input  in_valid, in_is_quad,
    input  in_x0_0, in_y0_0, in_x1_0, in_y1_0, in_x2_0, in_y2_0,
    input  in_x0_1, in_y0_1, in_x1_1, in_y1_1, in_x2_1, in_y2_1,
    input  out_ready,
    output in_ready,
    output out_valid, out_last, out_idx,
    output out_x0, out_y0, out_x1, out_y1, out_x2, out_y2
  );
endinterface

// File: rtl/gpu_tri_sequencer.sv
// gpu_tri_sequencer: captures one primitive (split quad = two triangles, or a
// single triangle) and issues its triangles one per transfer to rasterizer
// setup. Keeps a saturating issued-triangle counter.
// Optional build macro GPU_TRI_DEGEN_CULL_EN: drop zero-area triangles and
// count them on cull_count.
module gpu_tri_sequencer #(
  parameter int CW    = 16,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  gpu_tri_sequencer_if.slave bus,
  output logic               busy,
  output logic [CNT_W-1:0]   tri_count
`ifdef GPU_TRI_DEGEN_CULL_EN
  ,
  output logic [CNT_W-1:0]   cull_count
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND0 = 2'd1,
    SEND1 = 2'd2
  } state_t;

  // coordinate slot order: x0, y0, x1, y1, x2, y2
  localparam int NC = 6;

  state_t     state_reg, state_next;
  logic       quad_reg;
  logic [CNT_W-1:0] tri_count_reg;

  logic [CW-1:0] in_tri0   [NC];
  logic [CW-1:0] in_tri1   [NC];
  logic [CW-1:0] out_coord [NC];
  logic [CW-1:0] tri1_coord[NC];

  logic in_ready_w;
  logic out_valid_w;
  logic out_last_w;
  logic out_idx_w;
  logic load_tri0;
  logic load_tri1;
  logic done;
  logic out_fire;
  logic cur_deg;
  logic tri1_deg;

  assign in_tri0[0] = bus.in_x0_0;
  assign in_tri0[1] = bus.in_y0_0;
  assign in_tri0[2] = bus.in_x1_0;
  assign in_tri0[3] = bus.in_y1_0;
  assign in_tri0[4] = bus.in_x2_0;
  assign in_tri0[5] = bus.in_y2_0;

  assign in_tri1[0] = bus.in_x0_1;
  assign in_tri1[1] = bus.in_y0_1;
  assign in_tri1[2] = bus.in_x1_1;
  assign in_tri1[3] = bus.in_y1_1;
  assign in_tri1[4] = bus.in_x2_1;
  assign in_tri1[5] = bus.in_y2_1;

  // Per coordinate: the presented triangle register and the parked tri1.
  // The presented register is loaded with tri0 on capture and with the parked
  // tri1 when moving on, so it never changes while a triangle is on offer.
  genvar gi;
  generate
    for (gi = 0; gi < NC; gi++) begin : g_coord
      logic [CW-1:0] coord_reg;
      logic [CW-1:0] tri1_reg;

      // presented-coordinate and parked-tri1 registers
      always_ff @(posedge clk) begin
        if (rst) begin
          coord_reg <= '0;
          tri1_reg  <= '0;
        end else begin
          if (load_tri0) begin
            coord_reg <= in_tri0[gi];
          end else if (load_tri1) begin
            coord_reg <= tri1_reg;
          end
          // tri1 inputs of a single-triangle command are don't-care
          if (load_tri0 && bus.in_is_quad) begin
            tri1_reg <= in_tri1[gi];
          end
        end
      end

      assign out_coord[gi]  = coord_reg;
      assign tri1_coord[gi] = tri1_reg;
    end
  endgenerate

`ifdef GPU_TRI_DEGEN_CULL_EN
  localparam int OW = CW + 2;
  localparam int PW = 2 * OW;
  localparam int AW = 2 * CW + 5;

  logic [CNT_W-1:0] cull_count_reg;
  logic             cull_inc;

  // Doubled signed area; operands sign-extended so neither the differences
  // nor the products can overflow.
  function automatic logic signed [AW-1:0] area2(
    input logic [CW-1:0] x0, input logic [CW-1:0] y0,
    input logic [CW-1:0] x1, input logic [CW-1:0] y1,
    input logic [CW-1:0] x2, input logic [CW-1:0] y2
  );
    logic signed [OW-1:0] dx1, dy1, dx2, dy2;
    logic signed [PW-1:0] p1, p2;
    logic signed [AW-1:0] a1, a2;
    dx1 = {{2{x1[CW-1]}}, x1} - {{2{x0[CW-1]}}, x0};
    dy1 = {{2{y1[CW-1]}}, y1} - {{2{y0[CW-1]}}, y0};
    dx2 = {{2{x2[CW-1]}}, x2} - {{2{x0[CW-1]}}, x0};
    dy2 = {{2{y2[CW-1]}}, y2} - {{2{y0[CW-1]}}, y0};
    p1  = dx1 * dy2;
    p2  = dx2 * dy1;
    a1  = {p1[PW-1], p1};
    a2  = {p2[PW-1], p2};
    return a1 - a2;
  endfunction

  assign cur_deg  = (area2(out_coord[0], out_coord[1], out_coord[2],
                           out_coord[3], out_coord[4], out_coord[5]) == '0);
  assign tri1_deg = (area2(tri1_coord[0], tri1_coord[1], tri1_coord[2],
                           tri1_coord[3], tri1_coord[4], tri1_coord[5]) == '0);

  // saturating count of dropped zero-area triangles
  always_ff @(posedge clk) begin
    if (rst) begin
      cull_count_reg <= '0;
    end else if (cull_inc && (cull_count_reg != {CNT_W{1'b1}})) begin
      cull_count_reg <= cull_count_reg + 1'b1;
    end
  end

  assign cull_count = cull_count_reg;
`else
  assign cur_deg  = 1'b0;
  assign tri1_deg = 1'b0;
`endif

  // state register and captured quad flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      quad_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (load_tri0) begin
        quad_reg <= bus.in_is_quad;
      end
    end
  end

  // next state, handshake and register-load decode
  always_comb begin
    state_next  = state_reg;
    in_ready_w  = 1'b0;
    out_valid_w = 1'b0;
    out_last_w  = 1'b0;
    out_idx_w   = 1'b0;
    load_tri0   = 1'b0;
    load_tri1   = 1'b0;
    done        = 1'b0;
`ifdef GPU_TRI_DEGEN_CULL_EN
    cull_inc    = 1'b0;
`endif
    unique case (state_reg)
      IDLE: begin
        in_ready_w = 1'b1;
      end
      SEND0: begin
        if (cur_deg) begin
          // zero-area tri0: spend this cycle dropping it, then move on
`ifdef GPU_TRI_DEGEN_CULL_EN
          cull_inc = 1'b1;
`endif
          if (quad_reg) begin
            state_next = SEND1;
            load_tri1  = 1'b1;
          end else begin
            done = 1'b1;
          end
        end else begin
          out_valid_w = 1'b1;
          // a zero-area tri1 is never shown, so tri0 closes the primitive
          out_last_w  = !quad_reg || tri1_deg;
          if (bus.out_ready) begin
            if (out_last_w) begin
              done = 1'b1;
`ifdef GPU_TRI_DEGEN_CULL_EN
              cull_inc = quad_reg;
`endif
            end else begin
              state_next = SEND1;
              load_tri1  = 1'b1;
            end
          end
        end
      end
      SEND1: begin
        out_idx_w = 1'b1;
        if (cur_deg) begin
`ifdef GPU_TRI_DEGEN_CULL_EN
          cull_inc = 1'b1;
`endif
          done = 1'b1;
        end else begin
          out_valid_w = 1'b1;
          out_last_w  = 1'b1;
          if (bus.out_ready) begin
            done = 1'b1;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    // finishing a primitive frees the capture slot in the same cycle
    if (done) begin
      state_next = IDLE;
      in_ready_w = 1'b1;
    end
    if (in_ready_w && bus.in_valid) begin
      state_next = SEND0;
      load_tri0  = 1'b1;
    end
  end

  assign out_fire = out_valid_w && bus.out_ready;

  // saturating issued-triangle counter
  always_ff @(posedge clk) begin
    if (rst) begin
      tri_count_reg <= '0;
    end else if (out_fire && (tri_count_reg != {CNT_W{1'b1}})) begin
      tri_count_reg <= tri_count_reg + 1'b1;
    end
  end

  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = out_valid_w;
  assign bus.out_last  = out_last_w;
  assign bus.out_idx   = out_idx_w;
  assign bus.out_x0    = out_coord[0];
  assign bus.out_y0    = out_coord[1];
  assign bus.out_x1    = out_coord[2];
  assign bus.out_y1    = out_coord[3];
  assign bus.out_x2    = out_coord[4];
  assign bus.out_y2    = out_coord[5];

  assign busy      = (state_reg != IDLE);
  assign tri_count = tri_count_reg;

endmodule

// File: tb/tb_gpu_tri_sequencer.sv
// tb_gpu_tri_sequencer: randomized and directed stimulus checked against a
// queue-of-triangles reference model. Counter width is narrowed so that
// saturation is reached in a few hundred cycles.
`timescale 1ns/1ps
module tb_gpu_tri_sequencer;
  localparam int CW    = 16;
  localparam int CNT_W = 8;
  localparam int CMAX  = (1 << CNT_W) - 1;
  localparam int TW    = 6 * CW;
`ifdef GPU_TRI_DEGEN_CULL_EN
  localparam bit CULL = 1'b1;
`else
  localparam bit CULL = 1'b0;
`endif

  logic clk;
  logic rst;
  logic busy;
  logic [CNT_W-1:0] tri_count;
`ifdef GPU_TRI_DEGEN_CULL_EN
  logic [CNT_W-1:0] cull_count;
`endif

  gpu_tri_sequencer_if #(.CW(CW)) bus ();

  gpu_tri_sequencer #(.CW(CW), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .busy      (busy),
    .tri_count (tri_count)
`ifdef GPU_TRI_DEGEN_CULL_EN
    ,
    .cull_count(cull_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // one model entry = one cycle-consuming item the sequencer will issue:
  // a presented triangle, or (cull build) a dropped one
  typedef struct packed {
    logic [TW-1:0] c;
    logic          idx;
    logic          last;
    logic          bubble;
    logic          fin;
    logic          cull;
  } ent_t;

  ent_t q[$];
  int   exp_tri;
  int   exp_cull;
  int   n_cmp;
  int   n_err;
  int   cyc;
  int   n_xfer;
  int   fire_cyc[$];
  bit   fire_idx[$];
  bit   last_in_fire;

  logic          cur_q;
  logic [TW-1:0] cur_a;
  logic [TW-1:0] cur_b;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [TW-1:0] pk(input int x0, input int y0, input int x1,
                                       input int y1, input int x2, input int y2);
    return {x0[CW-1:0], y0[CW-1:0], x1[CW-1:0], y1[CW-1:0], x2[CW-1:0], y2[CW-1:0]};
  endfunction

  function automatic longint crd(input logic [TW-1:0] c, input int k);
    logic [CW-1:0] v;
    v = c[TW-1-k*CW -: CW];
    return longint'($signed(v));
  endfunction

  // zero doubled area <=> collinear or coincident vertices
  function automatic bit degenerate(input logic [TW-1:0] c);
    longint a;
    a = (crd(c, 2) - crd(c, 0)) * (crd(c, 5) - crd(c, 1))
      - (crd(c, 4) - crd(c, 0)) * (crd(c, 3) - crd(c, 1));
    return (a == 0);
  endfunction

  function automatic ent_t mk(input logic [TW-1:0] c, input bit idx, input bit last,
                              input bit bubble, input bit fin, input bit cull);
    ent_t e;
    e.c = c; e.idx = idx; e.last = last; e.bubble = bubble; e.fin = fin; e.cull = cull;
    return e;
  endfunction

  function automatic int rcoord();
    if ($urandom_range(0, 1) == 0) return int'($urandom_range(0, 6)) - 3;
    return int'($urandom);
  endfunction

  function automatic logic [TW-1:0] rtri();
    return pk(rcoord(), rcoord(), rcoord(), rcoord(), rcoord(), rcoord());
  endfunction

  task automatic apply(input logic quad, input logic [TW-1:0] a, input logic [TW-1:0] b);
    cur_q = quad; cur_a = a; cur_b = b;
    bus.in_is_quad = quad;
    {bus.in_x0_0, bus.in_y0_0, bus.in_x1_0, bus.in_y1_0, bus.in_x2_0, bus.in_y2_0} = a;
    {bus.in_x0_1, bus.in_y0_1, bus.in_x1_1, bus.in_y1_1, bus.in_x2_1, bus.in_y2_1} = b;
  endtask

  // expand an accepted primitive into the items it will produce
  task automatic push_prim();
    bit d0, d1;
    d0 = CULL && degenerate(cur_a);
    d1 = CULL && cur_q && degenerate(cur_b);
    if (!cur_q) begin
      if (d0) q.push_back(mk(cur_a, 0, 0, 1, 1, 1));
      else    q.push_back(mk(cur_a, 0, 1, 0, 0, 0));
    end else if (!d0) begin
      q.push_back(mk(cur_a, 0, d1, 0, 0, d1));
      if (!d1) q.push_back(mk(cur_b, 1, 1, 0, 0, 0));
    end else begin
      q.push_back(mk(cur_a, 0, 0, 1, 0, 1));
      if (d1) q.push_back(mk(cur_b, 1, 0, 1, 1, 1));
      else    q.push_back(mk(cur_b, 1, 1, 0, 0, 0));
    end
  endtask

  // one clock: sample outputs mid-cycle, compare, advance the model
  task automatic step();
    bit   head, exp_valid, exp_in_ready;
    ent_t e;
    #1;
    head         = (q.size() > 0);
    exp_valid    = 1'b0;
    exp_in_ready = 1'b1;
    if (head) begin
      exp_valid    = !q[0].bubble;
      exp_in_ready = q[0].bubble ? q[0].fin : (bus.out_ready && q[0].last);
    end
    chk("out_valid", bus.out_valid, exp_valid);
    chk("in_ready", bus.in_ready, exp_in_ready);
    chk("busy", busy, head);
    chk("tri_count", tri_count, exp_tri);
`ifdef GPU_TRI_DEGEN_CULL_EN
    chk("cull_count", cull_count, exp_cull);
`endif
    if (exp_valid) begin
      chk("out_coords", {bus.out_x0, bus.out_y0, bus.out_x1, bus.out_y1, bus.out_x2, bus.out_y2}, q[0].c);
      chk("out_idx", bus.out_idx, q[0].idx);
      chk("out_last", bus.out_last, q[0].last);
    end
    last_in_fire = bus.in_valid && exp_in_ready;
    if (head && (q[0].bubble || bus.out_ready)) begin
      e = q.pop_front();
      if (!e.bubble) begin
        if (exp_tri < CMAX) exp_tri++;
        n_xfer++;
        fire_cyc.push_back(cyc);
        fire_idx.push_back(e.idx);
        $display("xfer %0d: cyc=%0d idx=%0d last=%0d v0=(%0d,%0d)", n_xfer, cyc, e.idx, e.last,
                 crd(e.c, 0), crd(e.c, 1));
      end
      if (e.cull && exp_cull < CMAX) exp_cull++;
    end
    if (last_in_fire) push_prim();
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    exp_tri  = 0;
    exp_cull = 0;
  endtask

  task automatic reset_check(input string tag);
    #1;
    chk({tag, "_out_valid"}, bus.out_valid, 1'b0);
    chk({tag, "_in_ready"}, bus.in_ready, 1'b1);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_tri_count"}, tri_count, 0);
    chk({tag, "_out_last"}, bus.out_last, 1'b0);
    chk({tag, "_out_idx"}, bus.out_idx, 1'b0);
    chk({tag, "_out_coords"}, {bus.out_x0, bus.out_y0, bus.out_x1, bus.out_y1, bus.out_x2, bus.out_y2}, 0);
  endtask

  task automatic drain();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) step();
  endtask

  // issue one primitive and let it drain completely
  task automatic issue(input logic quad, input logic [TW-1:0] a, input logic [TW-1:0] b);
    apply(quad, a, b);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    step();
    drain();
  endtask

  logic [TW-1:0] qa, qb;
  logic [5:0]    seq;

  initial begin
    n_cmp = 0; n_err = 0; cyc = 0; n_xfer = 0;
    exp_tri = 0; exp_cull = 0;
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    apply(1'b0, '0, '0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    reset_check("reset");

    // quad issue: tri0 then tri1 on consecutive cycles
    qa = pk(0, 0, 10, 0, 0, 10);
    qb = pk(10, 0, 10, 10, 0, 10);
    issue(1'b1, qa, qb);
    #1;
    chk("quad_tri_count", tri_count, 2);

    // single triangle held under back-pressure
    apply(1'b0, pk(-5, 3, 7, -2, 1, 9), pk(1, 2, 3, 4, 5, 6));
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    step();
    bus.in_valid = 1'b0;
    repeat (4) step();
    bus.out_ready = 1'b1;
    step();
    step();
    chk("bp_busy", busy, 1'b0);

    // back-to-back quads: six transfers with no gap
    fire_cyc.delete();
    fire_idx.delete();
    bus.out_ready = 1'b1;
    for (int k = 0; k < 3; ) begin
      apply(1'b1, pk(3 * k, 0, 3 * k + 10, 0, 3 * k, 10), pk(3 * k + 10, 0, 3 * k + 10, 10, 3 * k, 10));
      bus.in_valid = 1'b1;
      step();
      if (last_in_fire) k++;
    end
    drain();
    chk("b2b_xfers", fire_cyc.size(), 6);
    if (fire_cyc.size() == 6) begin
      chk("b2b_span", fire_cyc[5] - fire_cyc[0], 5);
      seq = '0;
      for (int i = 0; i < 6; i++) seq = {seq[4:0], fire_idx[i]};
      chk("b2b_idx_seq", seq, 6'b010101);
    end

    // reset while tri1 is stalled on out_ready = 0
    apply(1'b1, qa, qb);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    step();
    bus.in_valid = 1'b0;
    step();
    bus.out_ready = 1'b0;
    step();
    step();
    do_reset();
    reset_check("midrst");

    // randomized traffic
    apply($urandom_range(0, 1), rtri(), rtri());
    for (int i = 0; i < 3000; i++) begin
      bus.in_valid  = ($urandom_range(0, 9) < 7);
      bus.out_ready = ($urandom_range(0, 9) < 6);
      step();
      if (last_in_fire) apply($urandom_range(0, 1), rtri(), rtri());
    end
    drain();

    // saturation: 254 triangles, then quads must stop at all-ones
    do_reset();
    reset_check("satrst");
    bus.out_ready = 1'b1;
    for (int k = 0; k < 127; ) begin
      apply(1'b1, qa, qb);
      bus.in_valid = 1'b1;
      step();
      if (last_in_fire) k++;
    end
    drain();
    #1;
    chk("sat_pre", tri_count, CMAX - 1);
    issue(1'b1, qa, qb);
    #1;
    chk("sat_hit", tri_count, CMAX);
    issue(1'b1, qa, qb);
    #1;
    chk("sat_hold", tri_count, CMAX);

`ifdef GPU_TRI_DEGEN_CULL_EN
    // collinear tri0 is dropped; tri1 alone is issued as the last triangle
    do_reset();
    fire_idx.delete();
    issue(1'b1, pk(0, 0, 5, 5, 10, 10), pk(0, 0, 4, 0, 0, 4));
    #1;
    chk("cull_count", cull_count, 1);
    chk("cull_tri_count", tri_count, 1);
    chk("cull_xfers", fire_idx.size(), 1);
    if (fire_idx.size() == 1) chk("cull_idx", fire_idx[0], 1'b1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/gpu_tri_sequencer.md
Name: gpu_tri_sequencer

Overview:
- Sits directly downstream of the quad splitter in the GPU polygon path.
- Captures one primitive: either two triangles (split quad) or one triangle (native 3-vertex command).
- Issues the triangles one at a time to the rasterizer setup stage over a valid/ready handshake.
- Keeps a saturating issued-triangle counter for debug readback.

Parameters:
- CW, 16, coordinate width; coordinates are two's-complement signed.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  primitive offered
- in_ready  out  1  primitive accepted when in_valid & in_ready (in_fire)
- in_is_quad  in  1  1: issue tri0 then tri1; 0: issue tri0 only
- in_x0_0, in_y0_0, in_x1_0, in_y1_0, in_x2_0, in_y2_0  in  CW each  triangle 0 vertices
- in_x0_1, in_y0_1, in_x1_1, in_y1_1, in_x2_1, in_y2_1  in  CW each  triangle 1 vertices
- out_valid  out  1  triangle presented
- out_ready  in  1  rasterizer accepts; transfer when out_valid & out_ready (out_fire)
- out_x0, out_y0, out_x1, out_y1, out_x2, out_y2  out  CW each  presented triangle
- out_last  out  1  presented triangle is the final one of its primitive
- out_idx  out  1  0 = triangle 0, 1 = triangle 1
- busy  out  1  state != IDLE
- tri_count  out  CNT_W  triangles issued since reset, saturating at all-ones

Behaviour:
- Reset: state = IDLE, out_valid = 0, out_last = 0, out_idx = 0, all out_x*/out_y* = 0, tri_count = 0, busy = 0.
- Reset mid-operation discards any held primitive. No partial triangle is emitted after rst deasserts.
- States: IDLE, SEND0, SEND1.
- IDLE:
  - in_ready = 1.
  - On in_fire: latch all 12 coordinates and in_is_quad, then go to SEND0.
- SEND0:
  - Registers drive tri0, out_valid = 1, out_idx = 0, out_last = !quad_q.
  - On out_fire with quad_q = 1: go to SEND1.
  - On out_fire with quad_q = 0: go to IDLE.
- SEND1:
  - Registers drive tri1, out_valid = 1, out_idx = 1, out_last = 1.
  - On out_fire: go to IDLE.
- Back-to-back:
  - in_ready is also 1 during the cycle in which out_fire & out_last occurs.
  - A simultaneous in_fire goes directly to SEND0 with the new primitive. There is no bubble cycle.
- Latency: in_fire in cycle N gives out_valid = 1 in cycle N+1. All outputs are registered; there is no combinational in-to-out path except the in_ready dependency on out_ready.
- AXI-style rules:
  - Once out_valid is asserted, out_x*/out_y*/out_idx/out_last hold stable until out_fire.
  - out_valid never drops without out_fire, except on rst.
- in_is_quad = 0: tri1 inputs are ignored and not latched.
- tri_count:
  - Increments by 1 on every out_fire.
  - Holds at 2^CNT_W-1; no wrap.
- Coordinates pass through bit-exact; there is no arithmetic on the issue path.

Optional Feature:
- Macro: GPU_TRI_DEGEN_CULL_EN.
- When defined:
  - Compute the signed doubled area of each latched triangle: A = (x1-x0)*(y2-y0) - (x2-x0)*(y1-y0).
  - Operands are sign-extended to CW+2 bits; the result is held at 2*CW+5 bits with no overflow.
  - A is computed from the latched registers, not from the inputs.
  - If A == 0 in SEND0 or SEND1: out_valid stays 0 for one cycle, then the state advances as if out_fire had occurred.
  - If the skipped triangle was the last, go to IDLE and assert in_ready that cycle.
  - out_last refers to the last non-culled triangle: if tri1 is degenerate, tri0 is presented with out_last = 1.
  - Adds output cull_count, CNT_W wide, saturating, incremented per culled triangle.
  - tri_count counts only issued triangles.
- When undefined: no area logic, cull_count port absent, every triangle issued.

Test Plan:
- Quad issue:
  - Stimulus: reset, then in_is_quad = 1, tri0 = (0,0),(10,0),(0,10), tri1 = (10,0),(10,10),(0,10); out_ready = 1.
  - Required: cycle N+1 out_idx = 0, out_last = 0, tri0 values; cycle N+2 out_idx = 1, out_last = 1, tri1 values; tri_count = 2.
- Single triangle with back-pressure:
  - Stimulus: in_is_quad = 0, tri0 = (-5,3),(7,-2),(1,9); out_ready = 0 for 4 cycles.
  - Required: outputs stable and out_valid = 1 throughout; in_ready = 0; after out_ready = 1 one transfer with out_last = 1, then busy = 0.
- Back-to-back:
  - Stimulus: in_valid held high with 3 quads; out_ready = 1.
  - Required: 6 consecutive out_fire with no gap cycles; out_idx sequence 0,1,0,1,0,1.
- Reset mid-primitive:
  - Stimulus: rst asserted while in SEND1 with out_ready = 0.
  - Required: next cycle out_valid = 0, tri_count = 0, in_ready = 1.
- Saturation:
  - Stimulus: force tri_count to 0xFFFE, issue one quad.
  - Required: tri_count = 0xFFFF after both transfers; no wrap to 0.
- With GPU_TRI_DEGEN_CULL_EN:
  - Stimulus: quad with tri0 = (0,0),(5,5),(10,10) (collinear) and tri1 = (0,0),(4,0),(0,4).
  - Required: only tri1 is issued, with out_idx = 1 and out_last = 1; cull_count = 1, tri_count = 1.
